// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage.
//   exe_cmd_e   : ALU/MUL operation codes carried in ID/EX exe_cmd
//   fwd_sel_e   : operand forwarding source select
//   mul_state_e : iterative multiplier FSM states
//   fwd_pick()  : forwarding priority (MEM over WB, never for r0)
package exe_stage_pkg;

  typedef enum logic [3:0] {
    EXE_ADD   = 4'd0,
    EXE_SUB   = 4'd1,
    EXE_AND   = 4'd2,
    EXE_OR    = 4'd3,
    EXE_NOR   = 4'd4,
    EXE_XOR   = 4'd5,
    EXE_SLL   = 4'd6,
    EXE_SRL   = 4'd7,
    EXE_SRA   = 4'd8,
    EXE_SLT   = 4'd9,
    EXE_MUL   = 4'd10,
    EXE_PASSB = 4'd11
  } exe_cmd_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  // r0 is never forwarded; the younger (MEM) producer wins over WB.
  function automatic fwd_sel_e fwd_pick(input logic src_nz, input logic mem_hit,
                                        input logic wb_hit);
    if (!src_nz)  return FWD_NONE;
    if (mem_hit)  return FWD_MEM;
    if (wb_hit)   return FWD_WB;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle for the execute stage.
//   master : upstream side (drives ID/EX fields, forward sources, flush;
//            observes stall and EX/MEM fields)
//   slave  : the execute stage itself
interface exe_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              flush;
  logic [3:0]        exe_cmd;
  logic [DATA_W-1:0] val1, val2, st_value_in;
  logic [REG_AW-1:0] src1, src2, dest_in;
  logic              mem_r_en_in, mem_w_en_in, wb_en_in;
  logic [REG_AW-1:0] mem_fwd_dest;
  logic              mem_fwd_wb_en;
  logic [DATA_W-1:0] mem_fwd_val;
  logic [REG_AW-1:0] wb_fwd_dest;
  logic              wb_fwd_wb_en;
  logic [DATA_W-1:0] wb_fwd_val;
  logic              stall;
  logic [DATA_W-1:0] alu_result, st_value;
  logic [REG_AW-1:0] dest;
  logic              mem_r_en, mem_w_en, wb_en;

  modport master (
    output flush, exe_cmd, val1, val2, st_value_in, src1, src2, dest_in,
           mem_r_en_in, mem_w_en_in, wb_en_in,
           mem_fwd_dest, mem_fwd_wb_en, mem_fwd_val,
           wb_fwd_dest, wb_fwd_wb_en, wb_fwd_val,
    input  stall, alu_result, st_value, dest, mem_r_en, mem_w_en, wb_en
  );

  modport slave (
    input  flush, exe_cmd, val1, val2, st_value_in, src1, src2, dest_in,
           mem_r_en_in, mem_w_en_in, wb_en_in,
           mem_fwd_dest, mem_fwd_wb_en, mem_fwd_val,
           wb_fwd_dest, wb_fwd_wb_en, wb_fwd_val,
    output stall, alu_result, st_value, dest, mem_r_en, mem_w_en, wb_en
  );
endinterface

// File: rtl/exe_stage_iter_mul.sv
// Iterative shift-add multiplier, one partial product per cycle.
//   clk, rst : clock, async active-low reset
//   start    : a MUL sits in EX (operands a/b valid, already forwarded)
//   flush    : abort and return to IDLE
//   busy     : combinational stall request (start cycle + all BUSY cycles)
//   done     : product final this cycle; EX/MEM may capture it
//   product  : low DATA_W bits of a*b
module iter_mul
  import exe_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  localparam int CW = $clog2(DATA_W);

  mul_state_e        state;
  logic [DATA_W-1:0] a_q, b_q, acc_q;
  logic [CW-1:0]     cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MUL_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      state <= MUL_IDLE;
      cnt_q <= '0;
    end else begin
      case (state)
        MUL_IDLE: if (start) begin
          a_q   <= a;
          b_q   <= b;
          acc_q <= '0;
          cnt_q <= '0;
          state <= MUL_BUSY;
        end
        MUL_BUSY: begin
          if (b_q[0]) acc_q <= acc_q + a_q;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) state <= MUL_DONE;
        end
        MUL_DONE: state <= MUL_IDLE;
        default:  state <= MUL_IDLE;
      endcase
    end
  end

  // DONE drops stall so upstream advances on the same edge that EX/MEM
  // takes the product. Reset forces stall low even with a MUL presented.
  assign busy    = rst && !flush &&
                   ((state == MUL_IDLE && start) || state == MUL_BUSY);
  assign done    = (state == MUL_DONE);
  assign product = acc_q;
endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding from MEM/WB, single-cycle ALU,
// iterative MUL with upstream stall, EX/MEM output register.
//   clk, rst : clock, async active-low reset
//   bus      : exe_stage_if slave (ID/EX inputs, forward sources, flush,
//              stall, registered EX/MEM outputs)
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic       clk,
  input  logic       rst,
  exe_stage_if.slave bus
);
  exe_cmd_e          cmd;
  fwd_sel_e          sel_a, sel_b;
  logic [DATA_W-1:0] fwd_a, fwd_b, fwd_st, op_b, alu_y, mul_p;
  logic              reg_type, is_mul, mul_busy, mul_done;

  assign cmd      = exe_cmd_e'(bus.exe_cmd);
  assign is_mul   = (cmd == EXE_MUL);
  // ADD..SLT and MUL take B from a register; the rest carry an immediate.
  assign reg_type = (bus.exe_cmd <= EXE_MUL);

  assign sel_a = fwd_pick(bus.src1 != '0,
                          bus.mem_fwd_wb_en && (bus.mem_fwd_dest == bus.src1),
                          bus.wb_fwd_wb_en  && (bus.wb_fwd_dest  == bus.src1));
  assign sel_b = fwd_pick(bus.src2 != '0,
                          bus.mem_fwd_wb_en && (bus.mem_fwd_dest == bus.src2),
                          bus.wb_fwd_wb_en  && (bus.wb_fwd_dest  == bus.src2));

  always_comb begin
    fwd_a  = bus.val1;
    fwd_b  = bus.val2;
    fwd_st = bus.st_value_in;
    case (sel_a)
      FWD_MEM: fwd_a = bus.mem_fwd_val;
      FWD_WB:  fwd_a = bus.wb_fwd_val;
      default: fwd_a = bus.val1;
    endcase
    // Store data shares src2 with operand B but has its own fallback.
    case (sel_b)
      FWD_MEM: begin fwd_b = bus.mem_fwd_val; fwd_st = bus.mem_fwd_val; end
      FWD_WB:  begin fwd_b = bus.wb_fwd_val;  fwd_st = bus.wb_fwd_val;  end
      default: begin fwd_b = bus.val2;        fwd_st = bus.st_value_in; end
    endcase
  end

  assign op_b = reg_type ? fwd_b : bus.val2;

  always_comb begin
    alu_y = '0;
    case (cmd)
      EXE_ADD:   alu_y = fwd_a + op_b;
      EXE_SUB:   alu_y = fwd_a - op_b;
      EXE_AND:   alu_y = fwd_a & op_b;
      EXE_OR:    alu_y = fwd_a | op_b;
      EXE_NOR:   alu_y = ~(fwd_a | op_b);
      EXE_XOR:   alu_y = fwd_a ^ op_b;
      EXE_SLL:   alu_y = fwd_a << op_b[4:0];
      EXE_SRL:   alu_y = fwd_a >> op_b[4:0];
      EXE_SRA:   alu_y = $signed(fwd_a) >>> op_b[4:0];
      EXE_SLT:   alu_y = {{(DATA_W-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
      EXE_PASSB: alu_y = op_b;
      default:   alu_y = '0;
    endcase
  end

  iter_mul #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (is_mul),
    .flush   (bus.flush),
    .a       (fwd_a),
    .b       (op_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_p)
  );

  assign bus.stall = mul_busy;

  // A flushed instruction, or a MUL still iterating, leaves a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.alu_result <= '0;
      bus.st_value   <= '0;
      bus.dest       <= '0;
      bus.mem_r_en   <= 1'b0;
      bus.mem_w_en   <= 1'b0;
      bus.wb_en      <= 1'b0;
    end else if (bus.flush || (is_mul && !mul_done)) begin
      bus.alu_result <= '0;
      bus.st_value   <= '0;
      bus.dest       <= '0;
      bus.mem_r_en   <= 1'b0;
      bus.mem_w_en   <= 1'b0;
      bus.wb_en      <= 1'b0;
    end else begin
      bus.alu_result <= is_mul ? mul_p : alu_y;
      bus.st_value   <= fwd_st;
      bus.dest       <= bus.dest_in;
      bus.mem_r_en   <= bus.mem_r_en_in;
      bus.mem_w_en   <= bus.mem_w_en_in;
      bus.wb_en      <= bus.wb_en_in;
    end
  end
endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: the driver computes each cycle's expected
// EX/MEM contents and stall from a behavioural model and queues them; two
// monitors pop and compare (outputs after the edge, stall mid-cycle).
module tb_exe_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exe_stage_if bus();
  exe_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] res;
    logic [31:0] st;
    logic [4:0]  dest;
    logic        r, w, wb;
  } exp_t;

  exp_t        out_q[$];
  logic        stall_q[$];
  int          total = 0;
  int          bad   = 0;
  int          mul_cyc = -1;   // cycles the current MUL has been in EX, -1 idle
  logic [31:0] mul_prod;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitors ----------------
  initial forever begin
    @(posedge clk); #1;
    if (out_q.size() > 0) begin
      exp_t e;
      e = out_q.pop_front();
      chk("alu_result", bus.alu_result, e.res);
      chk("st_value",   bus.st_value,   e.st);
      chk("dest",       32'(bus.dest),  32'(e.dest));
      chk("mem_r_en",   32'(bus.mem_r_en), 32'(e.r));
      chk("mem_w_en",   32'(bus.mem_w_en), 32'(e.w));
      chk("wb_en",      32'(bus.wb_en),    32'(e.wb));
    end
  end

  initial forever begin
    @(negedge clk);
    if (stall_q.size() > 0) begin
      logic s;
      s = stall_q.pop_front();
      chk("stall", 32'(bus.stall), 32'(s));
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd(input logic [4:0] s, input logic [31:0] dflt);
    if (s != 5'd0 && bus.mem_fwd_wb_en && bus.mem_fwd_dest == s) return bus.mem_fwd_val;
    if (s != 5'd0 && bus.wb_fwd_wb_en  && bus.wb_fwd_dest  == s) return bus.wb_fwd_val;
    return dflt;
  endfunction

  function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return ~(a | b);
      5:  return a ^ b;
      6:  return a << sh;
      7:  return a >> sh;
      8:  return a[31] ? ~((~a) >> sh) : (a >> sh);
      9:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      11: return b;
      default: return 32'd0;
    endcase
  endfunction

  // Predict this cycle from the current inputs, queue it, advance one clock.
  task automatic cycle();
    int          op;
    logic [31:0] a, b, st;
    exp_t        live, e;
    logic        stl;
    op   = int'(bus.exe_cmd);
    a    = fwd(bus.src1, bus.val1);
    st   = fwd(bus.src2, bus.st_value_in);
    b    = (op <= 10) ? fwd(bus.src2, bus.val2) : bus.val2;
    live = '{alu_ref(op, a, b), st, bus.dest_in, bus.mem_r_en_in, bus.mem_w_en_in, bus.wb_en_in};
    e    = '{default: '0};
    stl  = 1'b0;
    if (bus.flush) begin
      mul_cyc = -1;
    end else if (op == 10) begin
      if (mul_cyc < 0) begin
        mul_prod = a * b;
        mul_cyc  = 0;
      end
      if (mul_cyc == 33) begin
        e       = live;
        e.res   = mul_prod;
        mul_cyc = -1;
      end else begin
        stl = 1'b1;
        mul_cyc++;
      end
    end else begin
      e = live;
    end
    stall_q.push_back(stl);
    out_q.push_back(e);
    @(posedge clk); #2;
  endtask

  task automatic set_op(input int op, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                        input logic r, input logic w, input logic wb);
    bus.exe_cmd     = 4'(op);
    bus.val1        = v1;
    bus.val2        = v2;
    bus.st_value_in = v2 ^ 32'hA5A5_A5A5;
    bus.src1        = s1;
    bus.src2        = s2;
    bus.dest_in     = d;
    bus.mem_r_en_in = r;
    bus.mem_w_en_in = w;
    bus.wb_en_in    = wb;
  endtask

  task automatic set_fwd(input logic [4:0] md, input logic me, input logic [31:0] mv,
                         input logic [4:0] wd, input logic we, input logic [31:0] wv);
    bus.mem_fwd_dest  = md;
    bus.mem_fwd_wb_en = me;
    bus.mem_fwd_val   = mv;
    bus.wb_fwd_dest   = wd;
    bus.wb_fwd_wb_en  = we;
    bus.wb_fwd_val    = wv;
  endtask

  task automatic run_mul();
    for (int k = 0; k < 40 && mul_cyc >= 0; k++) cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.flush = 1'b0;
    set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("rst alu_result", bus.alu_result, 32'd0);
    chk("rst wb_en", 32'(bus.wb_en), 32'd0);
    chk("rst dest", 32'(bus.dest), 32'd0);
    chk("rst stall", 32'(bus.stall), 32'd0);
    rst = 1'b1;

    // plain ADD
    set_op(0, 5, 7, 1, 2, 4, 0, 0, 1); cycle();
    // forwarding: MEM over WB, r0 never forwarded, WB alone
    set_fwd(3, 1, 100, 3, 1, 50);
    set_op(1, 7, 1, 3, 0, 5, 0, 0, 1); cycle();
    set_op(1, 7, 1, 0, 0, 5, 0, 0, 1); cycle();
    set_fwd(3, 0, 100, 3, 1, 50);
    set_op(1, 7, 1, 3, 0, 5, 0, 0, 1); cycle();
    // store data forwarded, PASSB keeps immediate even on a src2 hit
    set_fwd(2, 1, 32'h1234_5678, 0, 0, 0);
    set_op(11, 3, 32'h40, 1, 2, 6, 0, 1, 0); cycle();
    set_fwd(0, 0, 0, 0, 0, 0);

    // boundaries
    set_op(9, 32'hFFFF_FFFF, 1, 1, 2, 7, 0, 0, 1); cycle();
    set_op(8, 32'h8000_0000, 4, 1, 2, 7, 0, 0, 1); cycle();
    set_op(0, 32'hFFFF_FFFF, 1, 1, 2, 7, 0, 0, 1); cycle();

    // full multiply
    set_op(10, 32'hFFFF_FFFF, 3, 1, 2, 8, 0, 0, 1); run_mul();

    // flush during BUSY, then a one-cycle ADD
    set_op(10, 9, 11, 1, 2, 9, 0, 0, 1);
    for (int k = 0; k < 11; k++) cycle();
    bus.flush = 1'b1; cycle(); bus.flush = 1'b0;
    set_op(0, 2, 3, 1, 2, 10, 0, 0, 1); cycle();

    // flush coincident with MUL start: no start
    set_op(10, 4, 5, 1, 2, 11, 0, 0, 1);
    bus.flush = 1'b1; cycle(); bus.flush = 1'b0;
    set_op(0, 20, 22, 1, 2, 11, 0, 0, 1); cycle();

    // async reset mid-multiply, then 6x7 from scratch
    set_op(10, 6, 7, 1, 2, 12, 0, 0, 1);
    for (int k = 0; k < 6; k++) cycle();
    #1 rst = 1'b0;
    #1;
    chk("arst stall", 32'(bus.stall), 32'd0);
    chk("arst alu_result", bus.alu_result, 32'd0);
    chk("arst wb_en", 32'(bus.wb_en), 32'd0);
    mul_cyc = -1;
    @(posedge clk); #2;
    rst = 1'b1;
    run_mul();

    // randomized traffic; ID/EX held while the model predicts a stall
    for (int n = 0; n < 400; n++) begin
      if (mul_cyc < 0) begin
        int op;
        op = int'($urandom_range(0, 15));
        set_op(op, $urandom, (op >= 6 && op <= 8) ? 32'($urandom_range(0, 31)) : $urandom,
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      set_fwd(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
      bus.flush = ($urandom_range(0, (mul_cyc < 0) ? 15 : 63) == 0);
      cycle();
    end
    bus.flush = 1'b0;
    run_mul();

    chk("queues drained", 32'(out_q.size() + stall_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage sitting directly downstream of the ID/EX pipeline register.
- Consumes the registered operands, destination, source indices and control bits, and resolves data hazards by forwarding from MEM and WB.
- Performs a single-cycle ALU op or a 32-cycle iterative multiply, stalling upstream while the multiply runs.
- Registers results into the EX/MEM pipeline fields that feed the memory stage.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register index width

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-low reset
flush  in  1  squash current EX instruction (branch redirect)
exe_cmd  in  4  operation code from ID/EX
val1  in  DATA_W  operand A from ID/EX
val2  in  DATA_W  operand B (reg or immediate) from ID/EX
st_value_in  in  DATA_W  store data from ID/EX
src1  in  REG_AW  source index of val1
src2  in  REG_AW  source index of val2/store data
dest_in  in  REG_AW  destination index
mem_r_en_in, mem_w_en_in, wb_en_in  in  1 each  control from ID/EX
mem_fwd_dest  in  REG_AW  EX/MEM destination (forward source)
mem_fwd_wb_en  in  1  EX/MEM writeback enable
mem_fwd_val  in  DATA_W  EX/MEM result
wb_fwd_dest, wb_fwd_wb_en, wb_fwd_val  in  REG_AW/1/DATA_W  MEM/WB forward source
stall  out  1  hold IF/ID and ID/EX (combinational)
alu_result  out  DATA_W  registered result to MEM
st_value  out  DATA_W  registered forwarded store data
dest  out  REG_AW  registered destination
mem_r_en, mem_w_en, wb_en  out  1 each  registered control

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (rst=0) at any time, including mid-multiply: all registered outputs 0, FSM IDLE, iteration counter 0, stall 0.
- Forwarding, operand A:
  - MEM source if mem_fwd_wb_en && mem_fwd_dest==src1 && src1!=0.
  - Else WB source under the same rule.
  - Else val1.
  - MEM has priority over WB.
- Forwarding, operand B and store data: same rule applied with src2.
  - Operand B is forwarded only for register-type commands (ADD..SLT, MUL); otherwise val2 (immediate) is used unmodified.
  - st_value is always forwarded.
- exe_cmd encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR, 6 SLL, 7 SRL, 8 SRA (shift amount = B[4:0]).
  - 9 SLT (signed, result 1/0), 10 MUL (low DATA_W bits of unsigned product), 11 PASSB (used for address calc with ADD-style val1+val2 forbidden; result = B).
  - 12-15 result 0.
- Wrap-around: arithmetic is modulo 2^DATA_W; no overflow flag.
- Non-MUL commands: latency 1. Result and control appear on EX/MEM outputs at the next clk edge; stall=0.
- MUL FSM, states IDLE, BUSY, DONE:
  - IDLE with exe_cmd==10 && !flush: latch forwarded A, B; clear accumulator and counter; go BUSY. stall=1. EX/MEM receives a bubble (wb_en, mem_r_en, mem_w_en = 0; data 0).
  - BUSY: each cycle, if B[0], acc += A; then A<<=1, B>>=1, counter++. After counter==31 go DONE. stall=1. EX/MEM receives bubbles.
  - DONE: stall=0. EX/MEM captures acc with the instruction's dest/control. Next state IDLE.
  - Total stall = 33 cycles; result visible 34 edges after the MUL first presents.
- Upstream holds ID/EX contents while stall=1. Operands are latched, so forward-source changes during BUSY are ignored.
- flush=1: EX/MEM captures a bubble that cycle. Any MUL in progress aborts to IDLE, counter cleared, stall drops in the same cycle (combinational).
- Flush and MUL start in the same cycle: flush wins, no start.
- dest==0 with wb_en_in=1 is passed through unchanged; register-file protection belongs downstream.

Decomposition:
- Shared package: exe_cmd encodings (EXE_ADD..EXE_PASSB), forwarding-select constants (FWD_NONE/FWD_MEM/FWD_WB), MUL FSM state encodings.
- One sub-module: iter_mul (start, flush, a, b → busy, done, product; contains FSM and counter).
- Forwarding muxes and ALU stay inline.

Test Plan:
- ADD val1=5, val2=7, no hazards -> next edge alu_result=12, wb_en=1, stall=0.
- SUB src1=3; mem_fwd_dest=3/wb_en=1/val=100; wb_fwd_dest=3/val=50; val2=1 -> alu_result=99 (MEM priority); repeat with src1=0 -> uses val1.
- MUL A=0xFFFF_FFFF, B=3 -> stall high exactly 33 cycles, EX/MEM bubbles, then alu_result=0xFFFF_FFFD.
- MUL started, flush at BUSY cycle 10 -> stall 0 same cycle, EX/MEM bubble, FSM IDLE; following ADD completes in 1 cycle.
- rst low during BUSY cycle 5 -> all outputs 0 immediately (asynchronous); after release, MUL 6×7 restarts from IDLE -> 42.
- SLT -1 vs 1 -> 1; SRA 0x8000_0000 by 4 -> 0xF800_0000; ADD 0xFFFF_FFFF+1 -> 0.
